// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter for one port of the dual-port RAM, with a built-in zero-fill clear sequence.
// Read data returns one cycle after the grant, tagged by a one-hot rvalid.
module ram_port_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 6,
   parameter int DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_we,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*DW-1:0]   req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rvalid,
   output logic [DW-1:0]        rdata,
   input  logic                 clr,
   output logic                 clr_busy,
   output logic                 clr_done,
   output logic                 ram_cs,
   output logic                 ram_we,
   output logic                 ram_re,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_wdata,
   input  logic [DW-1:0]        ram_rdata
);

   localparam int LW = $clog2(NREQ);

   typedef enum logic {ARB, CLEAR} state_t;

   state_t          state_reg, state_next;
   logic [NREQ-1:0] gnt_reg, gnt_next;
   logic [NREQ-1:0] rvalid_reg, rvalid_next;
   logic [LW-1:0]   last_reg, last_next;
   logic            clr_busy_reg, clr_busy_next;
   logic            clr_done_reg, clr_done_next;
   logic            ram_cs_reg, ram_cs_next;
   logic            ram_we_reg, ram_we_next;
   logic            ram_re_reg, ram_re_next;
   logic [AW-1:0]   ram_addr_reg, ram_addr_next;
   logic [DW-1:0]   ram_wdata_reg, ram_wdata_next;

   logic [NREQ-1:0] eligible;
   logic            found;
   logic [LW-1:0]   win;
   logic [LW-1:0]   idx;

   // The current grant holder is masked so a still-held req is not granted back-to-back.
   assign eligible = req & ~gnt_reg;

   always_comb begin
      found = 1'b0;
      win   = last_reg;
      idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = LW'((int'(last_reg) + k) % NREQ);
         if (!found && eligible[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ARB;
         gnt_reg       <= '0;
         rvalid_reg    <= '0;
         last_reg      <= LW'(NREQ - 1);
         clr_busy_reg  <= 1'b0;
         clr_done_reg  <= 1'b0;
         ram_cs_reg    <= 1'b0;
         ram_we_reg    <= 1'b0;
         ram_re_reg    <= 1'b0;
         ram_addr_reg  <= '0;
         ram_wdata_reg <= '0;
      end else begin
         state_reg     <= state_next;
         gnt_reg       <= gnt_next;
         rvalid_reg    <= rvalid_next;
         last_reg      <= last_next;
         clr_busy_reg  <= clr_busy_next;
         clr_done_reg  <= clr_done_next;
         ram_cs_reg    <= ram_cs_next;
         ram_we_reg    <= ram_we_next;
         ram_re_reg    <= ram_re_next;
         ram_addr_reg  <= ram_addr_next;
         ram_wdata_reg <= ram_wdata_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ARB:     if (clr) state_next = CLEAR;
         CLEAR:   if (ram_addr_reg == '1) state_next = ARB;
         default: state_next = ARB;
      endcase
   end

   always_comb begin
      gnt_next       = '0;
      rvalid_next    = gnt_reg & {NREQ{ram_re_reg}};
      last_next      = last_reg;
      clr_busy_next  = 1'b0;
      clr_done_next  = 1'b0;
      ram_cs_next    = 1'b0;
      ram_we_next    = 1'b0;
      ram_re_next    = 1'b0;
      ram_addr_next  = ram_addr_reg;
      ram_wdata_next = ram_wdata_reg;
      case (state_reg)
         ARB: begin
            if (clr) begin
               // The entry edge already issues the write to address 0.
               clr_busy_next  = 1'b1;
               ram_cs_next    = 1'b1;
               ram_we_next    = 1'b1;
               ram_addr_next  = '0;
               ram_wdata_next = '0;
            end else if (found) begin
               gnt_next[win]  = 1'b1;
               last_next      = win;
               ram_cs_next    = 1'b1;
               ram_we_next    = req_we[win];
               ram_re_next    = ~req_we[win];
               ram_addr_next  = req_addr[int'(win)*AW +: AW];
               ram_wdata_next = req_wdata[int'(win)*DW +: DW];
            end
         end
         CLEAR: begin
            if (ram_addr_reg == '1) begin
               clr_done_next = 1'b1;
            end else begin
               clr_busy_next  = 1'b1;
               ram_cs_next    = 1'b1;
               ram_we_next    = 1'b1;
               ram_addr_next  = ram_addr_reg + 1'b1;
               ram_wdata_next = '0;
            end
         end
         default: ;
      endcase
   end

   assign gnt       = gnt_reg;
   assign rvalid    = rvalid_reg;
   assign rdata     = ram_rdata;
   assign clr_busy  = clr_busy_reg;
   assign clr_done  = clr_done_reg;
   assign ram_cs    = ram_cs_reg;
   assign ram_we    = ram_we_reg;
   assign ram_re    = ram_re_reg;
   assign ram_addr  = ram_addr_reg;
   assign ram_wdata = ram_wdata_reg;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a vector table for arbitration and read/write paths,
// plus hand sequences for clear, clear-while-busy, and reset during clear or a read.
module tb_ram_port_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 6;
   localparam int DW   = 8;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req, req_we;
   logic [NREQ*AW-1:0] req_addr;
   logic [NREQ*DW-1:0] req_wdata;
   logic [NREQ-1:0]   gnt, rvalid;
   logic [DW-1:0]     rdata;
   logic              clr, clr_busy, clr_done;
   logic              ram_cs, ram_we, ram_re;
   logic [AW-1:0]     ram_addr;
   logic [DW-1:0]     ram_wdata;
   logic [DW-1:0]     ram_rdata;

   int errors = 0;
   int checks = 0;

   ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .req(req), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
      .clr(clr), .clr_busy(clr_busy), .clr_done(clr_done),
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_re(ram_re),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM port: registered read, word i preset to i*3+1 except word 5 = 0xA5.
   logic [DW-1:0] mem [0:63];
   bit mem_init_done = 1'b0;
   always @(posedge clk) begin
      if (!mem_init_done) begin
         for (int i = 0; i < 64; i++)
            mem[i[5:0]] <= (i == 5) ? 8'hA5 : 8'(i * 3 + 1);
         mem_init_done <= 1'b1;
         ram_rdata <= '0;
      end else begin
         if (ram_cs && ram_we) mem[ram_addr] <= ram_wdata;
         if (ram_cs && ram_re) ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct packed {
      logic              rst;
      logic [NREQ-1:0]   req;
      logic [NREQ-1:0]   we;
      logic [NREQ*AW-1:0] addr;
      logic [NREQ*DW-1:0] wdata;
      logic [NREQ-1:0]   exp_gnt;
      logic [NREQ-1:0]   exp_rvalid;
      logic              exp_cs;
      logic              exp_we;
      logic              exp_re;
      logic [AW-1:0]     exp_addr;
      logic [DW-1:0]     exp_rdata;
      logic [DW-1:0]     exp_wdata;
   } vec_t;

   vec_t vq[$];

   localparam logic [NREQ*AW-1:0] A_DEF = {6'd13, 6'd12, 6'd11, 6'd10};
   localparam logic [NREQ*AW-1:0] A_T1  = {6'd13, 6'd12, 6'd5,  6'd10};
   localparam logic [NREQ*AW-1:0] A_T4  = {6'd13, 6'd12, 6'd11, 6'd63};
   localparam logic [NREQ*AW-1:0] A_T5  = {6'd13, 6'd7,  6'd11, 6'd5};
   localparam logic [NREQ*DW-1:0] W_T4  = {8'h00, 8'h00, 8'h00, 8'h3C};

   task automatic add_vec(input logic r, input logic [3:0] rq, input logic [3:0] w,
                          input logic [23:0] a, input logic [31:0] wd,
                          input logic [3:0] eg, input logic [3:0] erv,
                          input logic ecs, input logic ewe, input logic ere,
                          input logic [5:0] ea, input logic [7:0] erd, input logic [7:0] ewd);
      vec_t v;
      v.rst = r; v.req = rq; v.we = w; v.addr = a; v.wdata = wd;
      v.exp_gnt = eg; v.exp_rvalid = erv; v.exp_cs = ecs; v.exp_we = ewe; v.exp_re = ere;
      v.exp_addr = ea; v.exp_rdata = erd; v.exp_wdata = ewd;
      vq.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_gnt"},    32'(gnt), 32'h0);
      chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
      chk({tag, "_busy"},   32'(clr_busy), 32'h0);
      chk({tag, "_done"},   32'(clr_done), 32'h0);
      chk({tag, "_ctl"},    32'({ram_cs, ram_we, ram_re}), 32'h0);
      chk({tag, "_addr"},   32'(ram_addr), 32'h0);
      chk({tag, "_wdata"},  32'(ram_wdata), 32'h0);
   endtask

   initial begin
      rst = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; clr = 1'b0;

      // reset
      add_vec(0, 4'b0000, 4'b0000, A_DEF, 0,    4'b0000, 4'b0000, 0,0,0, 6'd0,  8'h00, 8'h00);
      add_vec(0, 4'b0000, 4'b0000, A_DEF, 0,    4'b0000, 4'b0000, 0,0,0, 6'd0,  8'h00, 8'h00);
      // single read by requester 1 at address 5
      add_vec(1, 4'b0010, 4'b0000, A_T1,  0,    4'b0010, 4'b0000, 1,0,1, 6'd5,  8'h00, 8'h00);
      add_vec(1, 4'b0000, 4'b0000, A_T1,  0,    4'b0000, 4'b0010, 0,0,0, 6'd5,  8'hA5, 8'h00);
      add_vec(1, 4'b0000, 4'b0000, A_T1,  0,    4'b0000, 4'b0000, 0,0,0, 6'd5,  8'h00, 8'h00);
      // contention from reset: 0,1,2,3,0,1
      add_vec(0, 4'b0000, 4'b0000, A_DEF, 0,    4'b0000, 4'b0000, 0,0,0, 6'd0,  8'h00, 8'h00);
      add_vec(1, 4'b1111, 4'b0000, A_DEF, 0,    4'b0001, 4'b0000, 1,0,1, 6'd10, 8'h00, 8'h00);
      add_vec(1, 4'b1111, 4'b0000, A_DEF, 0,    4'b0010, 4'b0001, 1,0,1, 6'd11, 8'h1F, 8'h00);
      add_vec(1, 4'b1111, 4'b0000, A_DEF, 0,    4'b0100, 4'b0010, 1,0,1, 6'd12, 8'h22, 8'h00);
      add_vec(1, 4'b1111, 4'b0000, A_DEF, 0,    4'b1000, 4'b0100, 1,0,1, 6'd13, 8'h25, 8'h00);
      add_vec(1, 4'b1111, 4'b0000, A_DEF, 0,    4'b0001, 4'b1000, 1,0,1, 6'd10, 8'h28, 8'h00);
      add_vec(1, 4'b1111, 4'b0000, A_DEF, 0,    4'b0010, 4'b0001, 1,0,1, 6'd11, 8'h1F, 8'h00);
      // fairness: grant 2, held req2 not re-granted, then 1011 -> 3,0,1, then 2
      add_vec(1, 4'b0100, 4'b0000, A_DEF, 0,    4'b0100, 4'b0010, 1,0,1, 6'd12, 8'h22, 8'h00);
      add_vec(1, 4'b0100, 4'b0000, A_DEF, 0,    4'b0000, 4'b0100, 0,0,0, 6'd12, 8'h25, 8'h00);
      add_vec(1, 4'b1011, 4'b0000, A_DEF, 0,    4'b1000, 4'b0000, 1,0,1, 6'd13, 8'h00, 8'h00);
      add_vec(1, 4'b1011, 4'b0000, A_DEF, 0,    4'b0001, 4'b1000, 1,0,1, 6'd10, 8'h28, 8'h00);
      add_vec(1, 4'b1011, 4'b0000, A_DEF, 0,    4'b0010, 4'b0001, 1,0,1, 6'd11, 8'h1F, 8'h00);
      add_vec(1, 4'b1111, 4'b0000, A_DEF, 0,    4'b0100, 4'b0010, 1,0,1, 6'd12, 8'h22, 8'h00);
      add_vec(1, 4'b0000, 4'b0000, A_DEF, 0,    4'b0000, 4'b0100, 0,0,0, 6'd12, 8'h25, 8'h00);
      // write 0x3C to 63, then read it back (writes give no rvalid)
      add_vec(1, 4'b0001, 4'b0001, A_T4,  W_T4, 4'b0001, 4'b0000, 1,1,0, 6'd63, 8'h00, 8'h3C);
      add_vec(1, 4'b0000, 4'b0000, A_T4,  W_T4, 4'b0000, 4'b0000, 0,0,0, 6'd63, 8'h00, 8'h3C);
      add_vec(1, 4'b0001, 4'b0000, A_T4,  W_T4, 4'b0001, 4'b0000, 1,0,1, 6'd63, 8'h00, 8'h3C);
      add_vec(1, 4'b0000, 4'b0000, A_T4,  W_T4, 4'b0000, 4'b0001, 0,0,0, 6'd63, 8'h3C, 8'h3C);

      foreach (vq[n]) begin
         rst = vq[n].rst; req = vq[n].req; req_we = vq[n].we;
         req_addr = vq[n].addr; req_wdata = vq[n].wdata; clr = 1'b0;
         step();
         $display("vec %0d: req=%b gnt=%b rvalid=%b cs=%b we=%b re=%b addr=%0d rdata=%h",
                  n, req, gnt, rvalid, ram_cs, ram_we, ram_re, ram_addr, rdata);
         chk("gnt",    32'(gnt),    32'(vq[n].exp_gnt));
         chk("rvalid", 32'(rvalid), 32'(vq[n].exp_rvalid));
         chk("ctl",    32'({ram_cs, ram_we, ram_re}),
                       32'({vq[n].exp_cs, vq[n].exp_we, vq[n].exp_re}));
         chk("addr",   32'(ram_addr), 32'(vq[n].exp_addr));
         chk("busy",   32'(clr_busy), 32'h0);
         if (vq[n].exp_rvalid != 0) chk("rdata", 32'(rdata), 32'(vq[n].exp_rdata));
         if (vq[n].exp_we)          chk("wdata", 32'(ram_wdata), 32'(vq[n].exp_wdata));
      end

      // Clear entered the cycle after a read grant, with req2 pending.
      req = 4'b0001; req_we = '0; req_addr = A_T5; req_wdata = '0;
      step();
      $display("clr_pre: gnt=%b addr=%0d", gnt, ram_addr);
      chk("clr_pre_gnt", 32'(gnt), 32'b0001);
      req = 4'b0100; clr = 1'b1;
      step();
      clr = 1'b0;
      $display("clr_entry: gnt=%b busy=%b addr=%0d rvalid=%b rdata=%h", gnt, clr_busy, ram_addr, rvalid, rdata);
      chk("clr_entry_gnt",    32'(gnt), 32'h0);
      chk("clr_entry_busy",   32'(clr_busy), 32'h1);
      chk("clr_entry_ctl",    32'({ram_cs, ram_we, ram_re}), 32'b110);
      chk("clr_entry_addr",   32'(ram_addr), 32'h0);
      chk("clr_entry_wdata",  32'(ram_wdata), 32'h0);
      chk("clr_entry_rvalid", 32'(rvalid), 32'b0001);
      chk("clr_entry_rdata",  32'(rdata), 32'hA5);
      for (int i = 1; i < 64; i++) begin
         clr = (i == 30);
         step();
         $display("clr_walk: addr=%0d we=%b gnt=%b busy=%b", ram_addr, ram_we, gnt, clr_busy);
         chk("clr_walk_addr", 32'(ram_addr), 32'(i));
         chk("clr_walk_ctl",  32'({ram_cs, ram_we, ram_re, clr_busy, clr_done}), 32'b11010);
         chk("clr_walk_gnt",  32'(gnt), 32'h0);
      end
      clr = 1'b0;
      step();
      $display("clr_exit: busy=%b done=%b cs=%b gnt=%b", clr_busy, clr_done, ram_cs, gnt);
      chk("clr_exit_busy", 32'(clr_busy), 32'h0);
      chk("clr_exit_done", 32'(clr_done), 32'h1);
      chk("clr_exit_cs",   32'(ram_cs), 32'h0);
      chk("clr_exit_gnt",  32'(gnt), 32'h0);
      step();
      $display("clr_resume: gnt=%b addr=%0d done=%b", gnt, ram_addr, clr_done);
      chk("clr_resume_gnt",  32'(gnt), 32'b0100);
      chk("clr_resume_addr", 32'(ram_addr), 32'd7);
      chk("clr_resume_done", 32'(clr_done), 32'h0);
      req = 4'b0000;
      step();
      $display("clr_readback: rvalid=%b rdata=%h", rvalid, rdata);
      chk("clr_rb_rvalid", 32'(rvalid), 32'b0100);
      chk("clr_rb_rdata",  32'(rdata), 32'h0);
      begin
         int nz;
         nz = 0;
         for (int i = 0; i < 64; i++) if (mem[i[5:0]] != 0) nz++;
         chk("clr_nonzero_words", 32'(nz), 32'h0);
      end

      // Reset with a read in flight kills the rvalid.
      req = 4'b0010; req_addr = A_DEF;
      step();
      chk("rstrd_gnt", 32'(gnt), 32'b0010);
      req = 4'b0000; rst = 1'b0;
      step();
      $display("rst_read: gnt=%b rvalid=%b", gnt, rvalid);
      chk_all_zero("rst_read");
      rst = 1'b1;
      step();

      // Reset mid-clear at address 20, then a fresh clear starts at 0.
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int i = 1; i <= 20; i++) step();
      $display("mid_clear: addr=%0d busy=%b", ram_addr, clr_busy);
      chk("mid_clear_addr", 32'(ram_addr), 32'd20);
      rst = 1'b0;
      step();
      $display("rst_clear: busy=%b done=%b cs=%b addr=%0d", clr_busy, clr_done, ram_cs, ram_addr);
      chk_all_zero("rst_clear");
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_done", 32'({clr_done, clr_busy, ram_cs}), 32'h0);
      end
      clr = 1'b1;
      step();
      clr = 1'b0;
      $display("restart: busy=%b addr=%0d", clr_busy, ram_addr);
      chk("restart_busy", 32'(clr_busy), 32'h1);
      chk("restart_addr", 32'(ram_addr), 32'h0);
      step();
      chk("restart_addr1", 32'(ram_addr), 32'h1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
